// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Common-data-bus arbiter for the Tomasulo back end. Each functional-unit
// result channel pushes {data, tag, branch, taken} into its own small FIFO.
// Every cycle one non-empty channel is chosen round-robin. Its head entry is
// popped and registered onto the CDB, which feeds the reservation stations
// and the ROB. A flush drops every queued result, for example on a branch
// mispredict.
//
// Ports
//   clk               system clock; all state updates on the rising edge
//   reset             synchronous, active-low reset
//   flush             synchronous clear of all queued results
//   ch_valid[i]       channel i offers a result this cycle
//   ch_data           channel i data at [i*DATA_W +: DATA_W]
//   ch_tag            channel i tag at [i*TAG_W +: TAG_W]
//   ch_branch[i]      result is a branch resolution
//   ch_branch_taken   branch outcome; only meaningful with ch_branch
//   ch_ready[i]       channel i FIFO is not full
//   CDB_valid         registered broadcast valid
//   CDB_tag / CDB_data / CDB_branch / CDB_branch_taken
//                     broadcast payload; all zero when CDB_valid is 0
//   CDB_src           index of the channel that won the broadcast
//
// Handshake: a result transfers at a rising edge where ch_valid[i] and
// ch_ready[i] are both 1. ch_ready[i] depends only on registered state, so
// a unit may look at it before it decides to assert ch_valid[i]. If a unit
// asserts ch_valid[i] while ch_ready[i] is 0, the result is dropped and the
// unit must hold the result or retry it. The CDB side has no back-pressure:
// a broadcast is valid for exactly one cycle.
// -----------------------------------------------------------------------------
module cdb_arbiter #(
   parameter int NUM_CH     = 4,
   parameter int DATA_W     = 32,
   parameter int TAG_W      = 6,
   parameter int FIFO_DEPTH = 4,
   parameter int SRC_W      = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic [NUM_CH-1:0]        ch_valid,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   input  logic [NUM_CH*TAG_W-1:0]  ch_tag,
   input  logic [NUM_CH-1:0]        ch_branch,
   input  logic [NUM_CH-1:0]        ch_branch_taken,
   output logic [NUM_CH-1:0]        ch_ready,
   output logic                     CDB_valid,
   output logic [TAG_W-1:0]         CDB_tag,
   output logic [DATA_W-1:0]        CDB_data,
   output logic                     CDB_branch,
   output logic                     CDB_branch_taken,
   output logic [SRC_W-1:0]         CDB_src
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef struct packed {
      logic              branch;
      logic              taken;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } entry_t;

   // Per-channel FIFO storage and pointers
   entry_t           mem_q    [NUM_CH][FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q [NUM_CH];
   logic [PTR_W-1:0] wr_ptr_d [NUM_CH];
   logic [PTR_W-1:0] rd_ptr_q [NUM_CH];
   logic [PTR_W-1:0] rd_ptr_d [NUM_CH];
   logic [CNT_W-1:0] count_q  [NUM_CH];
   logic [CNT_W-1:0] count_d  [NUM_CH];

   // Round-robin priority pointer: the search for a winner starts here
   logic [SRC_W-1:0] rr_ptr_q;
   logic [SRC_W-1:0] rr_ptr_d;

   // Registered CDB
   logic              cdb_valid_q;
   logic [TAG_W-1:0]  cdb_tag_q;
   logic [DATA_W-1:0] cdb_data_q;
   logic              cdb_branch_q;
   logic              cdb_taken_q;
   logic [SRC_W-1:0]  cdb_src_q;

   logic [NUM_CH-1:0] push_en;
   logic [NUM_CH-1:0] pop_en;
   logic [NUM_CH-1:0] nonempty;
   entry_t            push_entry [NUM_CH];
   logic              grant_valid;
   logic [SRC_W-1:0]  grant_idx;
   entry_t            head;

   // -------------------------------------------------------------------------
   // Push side: ready comes from the registered count only. A full FIFO
   // therefore refuses a push even in the cycle where it is being popped.
   // -------------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         ch_ready[i]          = (count_q[i] != FULL_CNT);
         nonempty[i]          = (count_q[i] != '0);
         push_en[i]           = ch_valid[i] & ch_ready[i];
         push_entry[i].branch = ch_branch[i];
         push_entry[i].taken  = ch_branch_taken[i];
         push_entry[i].tag    = ch_tag[i*TAG_W +: TAG_W];
         push_entry[i].data   = ch_data[i*DATA_W +: DATA_W];
      end
   end

   // -------------------------------------------------------------------------
   // Round-robin pick. Each non-empty channel gets a distance from the
   // priority pointer (measured modulo NUM_CH), and the channel with the
   // smallest distance wins. The decision uses the counts from before this
   // edge's pushes, so there is no bypass from a unit straight to the CDB.
   // -------------------------------------------------------------------------
   always_comb begin
      int off;
      int best_off;
      off         = 0;
      best_off    = NUM_CH;
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         off = i - int'(rr_ptr_q);
         if (off < 0) begin
            off = off + NUM_CH;
         end
         if (nonempty[i] && (off < best_off)) begin
            best_off    = off;
            grant_valid = 1'b1;
            grant_idx   = SRC_W'(i);
         end
      end
   end

   always_comb begin
      head = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         pop_en[i] = grant_valid && (grant_idx == SRC_W'(i));
         if (pop_en[i]) begin
            head = mem_q[i][rd_ptr_q[i]];
         end
      end
   end

   // The pointer moves to the slot after the winner. When nothing is pending
   // it stays where it is.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_valid) begin
         if (int'(grant_idx) == NUM_CH - 1) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = grant_idx + SRC_W'(1);
         end
      end
   end

   // FIFO next state. A push and a pop in the same cycle leave count unchanged.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         wr_ptr_d[i] = wr_ptr_q[i];
         rd_ptr_d[i] = rd_ptr_q[i];
         count_d[i]  = count_q[i];
         if (push_en[i]) begin
            wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
         end
         if (pop_en[i]) begin
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
         end
         case ({push_en[i], pop_en[i]})
            2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
            2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
            default: count_d[i] = count_q[i];
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // State registers. Reset has priority over flush, and flush has priority
   // over pushes and pops, so any pending results are dropped silently.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            count_q[i]  <= '0;
         end
         rr_ptr_q     <= '0;
         cdb_valid_q  <= 1'b0;
         cdb_tag_q    <= '0;
         cdb_data_q   <= '0;
         cdb_branch_q <= 1'b0;
         cdb_taken_q  <= 1'b0;
         cdb_src_q    <= '0;
      end else if (flush) begin
         for (int i = 0; i < NUM_CH; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            count_q[i]  <= '0;
         end
         rr_ptr_q     <= '0;
         cdb_valid_q  <= 1'b0;
         cdb_tag_q    <= '0;
         cdb_data_q   <= '0;
         cdb_branch_q <= 1'b0;
         cdb_taken_q  <= 1'b0;
         cdb_src_q    <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            wr_ptr_q[i] <= wr_ptr_d[i];
            rd_ptr_q[i] <= rd_ptr_d[i];
            count_q[i]  <= count_d[i];
         end
         rr_ptr_q     <= rr_ptr_d;
         // head is all zero when there is no grant, so an idle CDB drives zeros
         cdb_valid_q  <= grant_valid;
         cdb_tag_q    <= head.tag;
         cdb_data_q   <= head.data;
         cdb_branch_q <= head.branch;
         cdb_taken_q  <= head.taken;
         cdb_src_q    <= grant_idx;
      end
   end

   // Storage has no reset. Entries are only read while count says they are
   // live.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (reset && !flush && push_en[i]) begin
            mem_q[i][wr_ptr_q[i]] <= push_entry[i];
         end
      end
   end

   assign CDB_valid        = cdb_valid_q;
   assign CDB_tag          = cdb_tag_q;
   assign CDB_data         = cdb_data_q;
   assign CDB_branch       = cdb_branch_q;
   assign CDB_branch_taken = cdb_taken_q;
   assign CDB_src          = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Bench for cdb_arbiter with the default parameters (4 channels, 32-bit data,
// 6-bit tags, 4-deep FIFOs). The bench keeps a queue of accepted results.
// Each broadcast must match the oldest pending entry of the winning channel.
// A table of per-cycle vectors and a few hand-written sequences check exact
// cycle timing, round-robin order and flush behaviour.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;
  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int TW  = 6;
  localparam int DEP = 4;
  localparam int SBW = 2 + 1 + 1 + TW + DW;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic [NCH-1:0]    ch_valid;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH*TW-1:0] ch_tag;
  logic [NCH-1:0]    ch_branch;
  logic [NCH-1:0]    ch_branch_taken;
  logic [NCH-1:0]    ch_ready;
  logic              CDB_valid;
  logic [TW-1:0]     CDB_tag;
  logic [DW-1:0]     CDB_data;
  logic              CDB_branch;
  logic              CDB_branch_taken;
  logic [1:0]        CDB_src;

  cdb_arbiter #(
    .NUM_CH(NCH), .DATA_W(DW), .TAG_W(TW), .FIFO_DEPTH(DEP)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ch_valid(ch_valid), .ch_data(ch_data), .ch_tag(ch_tag),
    .ch_branch(ch_branch), .ch_branch_taken(ch_branch_taken),
    .ch_ready(ch_ready),
    .CDB_valid(CDB_valid), .CDB_tag(CDB_tag), .CDB_data(CDB_data),
    .CDB_branch(CDB_branch), .CDB_branch_taken(CDB_branch_taken),
    .CDB_src(CDB_src)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard: entry = {ch, branch, taken, tag, data}
  logic [SBW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int pend     = 0;   // entries pending before the coming edge's pushes

  typedef struct packed {
    logic [3:0]  push;
    logic [23:0] tags;   // {t3, t2, t1, t0}
    logic [31:0] dat;
    logic [3:0]  br;
    logic [3:0]  tk;
    logic        ev;
    logic [1:0]  esrc;
    logic [5:0]  etag;
    logic [31:0] edat;
    logic        ebr;
    logic        etk;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic [3:0] push, input logic [23:0] tags,
                              input logic [31:0] dat, input logic [3:0] br,
                              input logic [3:0] tk, input logic ev,
                              input logic [1:0] esrc, input logic [5:0] etag,
                              input logic [31:0] edat, input logic ebr,
                              input logic etk);
    vec_t v;
    v.push = push; v.tags = tags; v.dat = dat; v.br = br; v.tk = tk;
    v.ev = ev; v.esrc = esrc; v.etag = etag; v.edat = edat;
    v.ebr = ebr; v.etk = etk;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int model_cnt(input int ch);
    int n = 0;
    foreach (exp_q[j]) if (int'(exp_q[j][SBW-1 -: 2]) == ch) n++;
    return n;
  endfunction

  task automatic clear_inputs();
    ch_valid = '0; ch_data = '0; ch_tag = '0;
    ch_branch = '0; ch_branch_taken = '0; flush = 1'b0;
  endtask

  // driver: offer a result on channel ch; model accepts only if not full
  task automatic drive_push(input int ch, input logic [5:0] t, input logic [31:0] d,
                            input logic b, input logic k);
    logic [1:0] chb;
    chb = ch[1:0];
    ch_valid[ch]         = 1'b1;
    ch_data[ch*DW +: DW] = d;
    ch_tag[ch*TW +: TW]  = t;
    ch_branch[ch]        = b;
    ch_branch_taken[ch]  = k;
    if (reset && !flush && model_cnt(ch) != DEP)
      exp_q.push_back({chb, b, k, t, d});
  endtask

  // one clock: edge, then monitor/scoreboard and ready checks, then idle inputs
  task automatic cycle();
    int idx;
    logic [3:0] exp_rdy;
    @(posedge clk);
    #1;
    if (!reset) begin
      chk("rst_cdb", 64'({CDB_valid, CDB_src, CDB_tag, CDB_data, CDB_branch, CDB_branch_taken}), 64'd0);
      exp_q.delete();
    end else if (flush) begin
      chk("flush_cdb", 64'({CDB_valid, CDB_src, CDB_tag, CDB_data, CDB_branch, CDB_branch_taken}), 64'd0);
      exp_q.delete();
    end else begin
      chk("cdb_valid", 64'(CDB_valid), 64'(pend != 0));
      if (CDB_valid) begin
        idx = -1;
        foreach (exp_q[j]) if (idx < 0 && exp_q[j][SBW-1 -: 2] == CDB_src) idx = j;
        if (idx < 0) begin
          n_checks++;
          $display("FAIL sb_unexpected: got src %0d tag %0h expected no broadcast", CDB_src, CDB_tag);
        end else begin
          chk("sb_entry", 64'({CDB_src, CDB_branch, CDB_branch_taken, CDB_tag, CDB_data}), 64'(exp_q[idx]));
          exp_q.delete(idx);
        end
      end else begin
        chk("cdb_idle_zero", 64'({CDB_src, CDB_tag, CDB_data, CDB_branch, CDB_branch_taken}), 64'd0);
      end
    end
    for (int c = 0; c < NCH; c++) exp_rdy[c] = (model_cnt(c) != DEP);
    chk("ch_ready", 64'(ch_ready), 64'(exp_rdy));
    pend = exp_q.size();
    clear_inputs();
  endtask

  initial begin
    int prev;
    int seq [NCH];
    logic [3:0] saw_full;

    // contention, then ch1+ch3, single ch2 result, then branch pair
    tbl[0]  = mk(4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, 32'hA0A0_0000, 4'b0, 4'b0, 1'b0, 2'd0, 6'd0,  32'd0, 1'b0, 1'b0);
    tbl[1]  = mk(4'b0000, 24'd0, 32'd0, 4'b0, 4'b0, 1'b1, 2'd0, 6'd1,  32'hA0A0_0000, 1'b0, 1'b0);
    tbl[2]  = mk(4'b0000, 24'd0, 32'd0, 4'b0, 4'b0, 1'b1, 2'd1, 6'd2,  32'hA0A0_0000, 1'b0, 1'b0);
    tbl[3]  = mk(4'b0000, 24'd0, 32'd0, 4'b0, 4'b0, 1'b1, 2'd2, 6'd3,  32'hA0A0_0000, 1'b0, 1'b0);
    tbl[4]  = mk(4'b0000, 24'd0, 32'd0, 4'b0, 4'b0, 1'b1, 2'd3, 6'd4,  32'hA0A0_0000, 1'b0, 1'b0);
    tbl[5]  = mk(4'b0000, 24'd0, 32'd0, 4'b0, 4'b0, 1'b0, 2'd0, 6'd0,  32'd0, 1'b0, 1'b0);
    tbl[6]  = mk(4'b1010, {6'd6, 6'd0, 6'd5, 6'd0}, 32'hB0B0_0000, 4'b0, 4'b0, 1'b0, 2'd0, 6'd0, 32'd0, 1'b0, 1'b0);
    tbl[7]  = mk(4'b0000, 24'd0, 32'd0, 4'b0, 4'b0, 1'b1, 2'd1, 6'd5,  32'hB0B0_0000, 1'b0, 1'b0);
    tbl[8]  = mk(4'b0000, 24'd0, 32'd0, 4'b0, 4'b0, 1'b1, 2'd3, 6'd6,  32'hB0B0_0000, 1'b0, 1'b0);
    tbl[9]  = mk(4'b0000, 24'd0, 32'd0, 4'b0, 4'b0, 1'b0, 2'd0, 6'd0,  32'd0, 1'b0, 1'b0);
    tbl[10] = mk(4'b0100, {6'd0, 6'h15, 6'd0, 6'd0}, 32'hDEAD_BEEF, 4'b0, 4'b0, 1'b0, 2'd0, 6'd0, 32'd0, 1'b0, 1'b0);
    tbl[11] = mk(4'b0000, 24'd0, 32'd0, 4'b0, 4'b0, 1'b1, 2'd2, 6'h15, 32'hDEAD_BEEF, 1'b0, 1'b0);
    tbl[12] = mk(4'b0000, 24'd0, 32'd0, 4'b0, 4'b0, 1'b0, 2'd0, 6'd0,  32'd0, 1'b0, 1'b0);
    tbl[13] = mk(4'b0001, {18'd0, 6'h08}, 32'hC0C0_0000, 4'b0001, 4'b0001, 1'b0, 2'd0, 6'd0, 32'd0, 1'b0, 1'b0);
    tbl[14] = mk(4'b0001, {18'd0, 6'h09}, 32'hC1C1_0000, 4'b0000, 4'b0000, 1'b1, 2'd0, 6'h08, 32'hC0C0_0000, 1'b1, 1'b1);
    tbl[15] = mk(4'b0000, 24'd0, 32'd0, 4'b0, 4'b0, 1'b1, 2'd0, 6'h09, 32'hC1C1_0000, 1'b0, 1'b0);
    tbl[16] = mk(4'b0000, 24'd0, 32'd0, 4'b0, 4'b0, 1'b0, 2'd0, 6'd0,  32'd0, 1'b0, 1'b0);

    // reset held 3 cycles with all channels pushing
    reset = 1'b0;
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      ch_valid = 4'b1111;
      ch_tag   = {6'h3A, 6'h3B, 6'h3C, 6'h3D};
      cycle();
      chk("rst_ready", 64'(ch_ready), 64'hF);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("post_rst_idle", 64'(CDB_valid), 64'd0);
    end

    // table-driven vectors
    for (int r = 0; r < 17; r++) begin
      for (int c = 0; c < NCH; c++)
        if (tbl[r].push[c])
          drive_push(c, tbl[r].tags[c*TW +: TW], tbl[r].dat, tbl[r].br[c], tbl[r].tk[c]);
      cycle();
      chk($sformatf("tbl%0d_valid", r), 64'(CDB_valid), 64'(tbl[r].ev));
      chk($sformatf("tbl%0d_out", r),
          64'({CDB_src, CDB_tag, CDB_data, CDB_branch, CDB_branch_taken}),
          tbl[r].ev ? 64'({tbl[r].esrc, tbl[r].etag, tbl[r].edat, tbl[r].ebr, tbl[r].etk}) : 64'd0);
    end

    // full / back-pressure: every channel offers a result every cycle
    saw_full = '0;
    prev = -1;
    for (int c = 0; c < NCH; c++) seq[c] = 0;
    for (int i = 0; i < 40; i++) begin
      for (int c = 0; c < NCH; c++) begin
        logic [1:0] cb;
        logic [3:0] sb;
        cb = c[1:0];
        sb = seq[c][3:0];
        if (model_cnt(c) != DEP) seq[c]++;
        drive_push(c, {cb, sb}, 32'($urandom_range(0, 32'h7FFF_FFFF)), 1'b0, 1'b0);
      end
      cycle();
      for (int c = 0; c < NCH; c++) if (!ch_ready[c]) saw_full[c] = 1'b1;
      if (CDB_valid) begin
        if (prev >= 0) chk("rr_rotate", 64'(CDB_src), 64'((prev + 1) % NCH));
        prev = int'(CDB_src);
      end
    end
    chk("saw_full", 64'(saw_full), 64'hF);
    for (int i = 0; i < 20; i++) cycle();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    // flush with results pending on ch0 and ch3, plus a ch1 push in the flush cycle
    for (int i = 0; i < 4; i++) begin
      drive_push(0, 6'(6'h30 + i), 32'hF0F0_0000, 1'b0, 1'b0);
      if (i < 3) drive_push(3, 6'(6'h38 + i), 32'hF3F3_0000, 1'b0, 1'b0);
      cycle();
    end
    flush = 1'b1;
    drive_push(1, 6'h3F, 32'hF1F1_F1F1, 1'b0, 1'b0);
    cycle();
    chk("flush_ready", 64'(ch_ready), 64'hF);
    chk("flush_valid", 64'(CDB_valid), 64'd0);
    for (int i = 0; i < 6; i++) cycle();
    // the priority pointer restarts at 0, so ch1 wins over ch3
    drive_push(3, 6'h21, 32'h0000_0021, 1'b0, 1'b0);
    drive_push(1, 6'h20, 32'h0000_0020, 1'b0, 1'b0);
    cycle();
    cycle();
    chk("post_flush_first", 64'({CDB_valid, CDB_src}), 64'({1'b1, 2'd1}));
    cycle();
    chk("post_flush_second", 64'({CDB_valid, CDB_src}), 64'({1'b1, 2'd3}));
    cycle();
    cycle();
    chk("final_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
